// File: rtl/riscv_pkg.sv
// Shared RV32 types used between fetch, align and decode stages.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } ifu_t;

endpackage

// File: rtl/instr_aligner.sv
// Fetch-to-decode aligner: splits 32-bit fetch words into whole RV32IC instructions,
// rejoining 32-bit instructions that straddle two words, one instruction per cycle.
module instr_aligner (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  riscv_pkg::ifu_t    in_ifu,
  output logic               out_valid,
  input  logic               out_ready,
  output riscv_pkg::ifu_t    out_ifu,
  output logic               out_compressed,
  output logic [63:0]        out_seq
);

  logic            pend_v_q, pend_v_d;
  logic [15:0]     pend_data_q, pend_data_d;
  logic [31:0]     pend_addr_q, pend_addr_d;

  logic            out_valid_q;
  riscv_pkg::ifu_t out_ifu_q;
  logic            out_comp_q;
  logic [63:0]     out_seq_q;
  logic [63:0]     seq_q;

  logic            adv;
  logic            pend_comp;
  logic [15:0]     in_lo, in_hi;
  logic [31:0]     in_base;

  logic            emit;
  logic [31:0]     emit_addr;
  logic [31:0]     emit_data;

  assign adv       = !out_valid_q || out_ready;
  assign pend_comp = pend_data_q[1:0] != 2'b11;
  assign in_lo     = in_ifu.data[15:0];
  assign in_hi     = in_ifu.data[31:16];
  assign in_base   = {in_ifu.addr[31:2], 2'b00};

  // in_ready is a function of adv, flush and pend state only, never of in_valid.
  always_comb begin
    in_ready    = 1'b0;
    emit        = 1'b0;
    emit_addr   = '0;
    emit_data   = '0;
    pend_v_d    = pend_v_q;
    pend_data_d = pend_data_q;
    pend_addr_d = pend_addr_q;

    if (!flush) begin
      if (pend_v_q) begin
        if (pend_comp) begin
          // Drain the buffered compressed halfword before taking new input.
          if (adv) begin
            emit      = 1'b1;
            emit_addr = pend_addr_q;
            emit_data = {16'h0000, pend_data_q};
            pend_v_d  = 1'b0;
          end
        end else begin
          in_ready = adv;
          if (in_valid && adv) begin
            emit        = 1'b1;
            emit_addr   = pend_addr_q;
            emit_data   = {in_lo, pend_data_q};
            pend_data_d = in_hi;
            pend_addr_d = in_base + 32'd2;
          end
        end
      end else begin
        in_ready = adv;
        if (in_valid && adv) begin
          if (in_ifu.addr[1]) begin
            // Redirect into the upper half: only the upper halfword is live.
            pend_v_d    = 1'b1;
            pend_data_d = in_hi;
            pend_addr_d = in_ifu.addr;
          end else if (in_lo[1:0] != 2'b11) begin
            emit        = 1'b1;
            emit_addr   = in_ifu.addr;
            emit_data   = {16'h0000, in_lo};
            pend_v_d    = 1'b1;
            pend_data_d = in_hi;
            pend_addr_d = in_ifu.addr + 32'd2;
          end else begin
            emit      = 1'b1;
            emit_addr = in_ifu.addr;
            emit_data = in_ifu.data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q    <= 1'b0;
      pend_data_q <= '0;
      pend_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_ifu_q   <= '0;
      out_comp_q  <= 1'b0;
      out_seq_q   <= '0;
      seq_q       <= '0;
    end else if (flush) begin
      // seq_q deliberately survives a redirect.
      out_valid_q <= 1'b0;
      pend_v_q    <= 1'b0;
    end else if (adv) begin
      out_valid_q <= emit;
      pend_v_q    <= pend_v_d;
      pend_data_q <= pend_data_d;
      pend_addr_q <= pend_addr_d;
      if (emit) begin
        out_ifu_q.addr <= emit_addr;
        out_ifu_q.data <= emit_data;
        out_comp_q     <= emit_data[1:0] != 2'b11;
        out_seq_q      <= seq_q;
        seq_q          <= seq_q + 64'd1;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_ifu        = out_ifu_q;
  assign out_compressed = out_comp_q;
  assign out_seq        = out_seq_q;

endmodule

// File: tb/tb_instr_aligner.sv
// Scoreboard bench for instr_aligner: directed fetch words, expected instructions queued
// at issue time and checked by an independent output monitor.
module tb_instr_aligner;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  riscv_pkg::ifu_t in_ifu;
  logic            out_valid;
  logic            out_ready;
  riscv_pkg::ifu_t out_ifu;
  logic            out_compressed;
  logic [63:0]     out_seq;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        comp;
    logic [63:0] seq;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_seq  = 0;

  instr_aligner dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ifu         (in_ifu),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ifu        (out_ifu),
    .out_compressed (out_compressed),
    .out_seq        (out_seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.comp = c;
    e.seq  = exp_seq;
    exp_seq++;
    sb.push_back(e);
  endtask

  // Present one word, wait for acceptance, return 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    in_valid    = 1'b1;
    in_ifu.addr = a;
    in_ifu.data = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck low for addr 0x%0h", a);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got addr 0x%0h data 0x%0h seq %0d, expected none",
                 out_ifu.addr, out_ifu.data, out_seq);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_ifu.addr !== e.addr || out_ifu.data !== e.data ||
            out_compressed !== e.comp || out_seq !== e.seq) begin
          n_fail++;
          $display("FAIL output: got addr 0x%0h data 0x%0h c %0b seq %0d, expected addr 0x%0h data 0x%0h c %0b seq %0d",
                   out_ifu.addr, out_ifu.data, out_compressed, out_seq,
                   e.addr, e.data, e.comp, e.seq);
        end
      end
    end
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ifu    = '0;
    out_ready = 1'b1;

    #3;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_ifu", 64'(out_ifu), 64'd0);
    chk("reset_out_comp", 64'(out_compressed), 64'd0);
    chk("reset_out_seq", out_seq, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Aligned 32-bit stream, one cycle latency.
    push(32'h100, 32'h00500093, 1'b0);
    push(32'h104, 32'h00A00113, 1'b0);
    push(32'h108, 32'h002081B3, 1'b0);
    send(32'h100, 32'h00500093);
    chk("lat_valid_100", 64'(out_valid), 64'd1);
    chk("lat_addr_100", 64'(out_ifu.addr), 64'h100);
    send(32'h104, 32'h00A00113);
    chk("lat_addr_104", 64'(out_ifu.addr), 64'h104);
    send(32'h108, 32'h002081B3);
    chk("lat_addr_108", 64'(out_ifu.addr), 64'h108);
    idle(2);

    // Two compressed instructions in one word.
    push(32'h200, 32'h00004505, 1'b1);
    push(32'h202, 32'h00004585, 1'b1);
    send(32'h200, 32'h45854505);
    chk("cc_in_ready_low", 64'(in_ready), 64'd0);
    idle(3);

    // Compressed then a 32-bit instruction straddling into the next word.
    push(32'h300, 32'h00004501, 1'b1);
    push(32'h302, 32'h00500093, 1'b0);
    push(32'h306, 32'h00004501, 1'b1);
    send(32'h300, 32'h00934501);
    send(32'h304, 32'h45010050);
    idle(3);

    // Redirect into an upper halfword.
    flush = 1'b1;
    #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    push(32'h402, 32'h00004505, 1'b1);
    send(32'h402, 32'h4505BEEF);
    chk("redir_no_low_out", 64'(out_valid), 64'd0);
    idle(3);

    // Back-pressure with a waiting input word.
    out_ready = 1'b0;
    push(32'h500, 32'h00A00113, 1'b0);
    push(32'h504, 32'h002081B3, 1'b0);
    send(32'h500, 32'h00A00113);
    in_valid    = 1'b1;
    in_ifu.addr = 32'h504;
    in_ifu.data = 32'h002081B3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_addr", 64'(out_ifu.addr), 64'h500);
      chk("bp_seq", out_seq, 64'd9);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    idle(2);

    // Flush with a straddle upper half pending and a concurrent input word.
    push(32'h600, 32'h00004501, 1'b1);
    send(32'h600, 32'h01234501);
    flush       = 1'b1;
    in_valid    = 1'b1;
    in_ifu.addr = 32'h604;
    in_ifu.data = 32'h45010050;
    #1 chk("flush2_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush2_out_valid", 64'(out_valid), 64'd0);
    idle(3);
    push(32'h700, 32'h00A00113, 1'b0);
    send(32'h700, 32'h00A00113);
    idle(2);

    // Asynchronous reset while an output is held under back-pressure.
    out_ready = 1'b0;
    send(32'h800, 32'h002081B3);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_seq", out_seq, 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    exp_seq   = 0;
    push(32'h900, 32'h00500093, 1'b0);
    send(32'h900, 32'h00500093);
    idle(2);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
